// File: rtl/stopwatch_multimode.sv
// Multimode stopwatch/timer: prescaled up or down count with preload,
// one-shot expiry pulse and a lap-capture FIFO.
module stopwatch_multimode #(
    parameter int CLK_PER_SEC = 100_000_000,
    parameter int MIN_WIDTH   = 8,
    parameter int LAP_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 reset,
    input  logic                 mode_down,
    input  logic                 load,
    input  logic [MIN_WIDTH-1:0] load_min,
    input  logic [5:0]           load_sec,
    input  logic                 lap,
    input  logic                 lap_rd,
    output logic [MIN_WIDTH-1:0] minutes,
    output logic [5:0]           seconds,
    output logic [1:0]           status,
    output logic                 expired,
    output logic                 lap_valid,
    output logic [MIN_WIDTH-1:0] lap_min,
    output logic [5:0]           lap_sec,
    output logic                 lap_full,
    output logic                 lap_ovf
);

    localparam int PW = $clog2(CLK_PER_SEC);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_EXP   = 2'b11
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_presc;
    logic [MIN_WIDTH-1:0]  r_min;
    logic [5:0]            r_sec;
    logic                  r_mode_down;
    logic                  r_expired;

    logic [MIN_WIDTH-1:0]  r_mem_min [LAP_DEPTH];
    logic [5:0]            r_mem_sec [LAP_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_lap_valid;
    logic                  r_lap_full;
    logic                  r_lap_ovf;
    logic [MIN_WIDTH-1:0]  r_head_min;
    logic [5:0]            r_head_sec;

    logic [5:0]            w_load_sec;
    logic                  w_zero;
    logic [MIN_WIDTH-1:0]  w_up_min;
    logic [5:0]            w_up_sec;
    logic [MIN_WIDTH-1:0]  w_dn_min;
    logic [5:0]            w_dn_sec;
    logic                  w_dn_zero;
    logic                  w_pop;
    logic                  w_want_push;
    logic                  w_push;
    logic                  w_drop;
    logic [AW-1:0]         w_rd_next;
    logic [CW-1:0]         w_cnt_next;
    logic [MIN_WIDTH-1:0]  w_head_min;
    logic [5:0]            w_head_sec;

    // Next-count arithmetic for both directions and preload clamping
    always_comb begin
        w_load_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
        w_zero     = (r_min == '0) && (r_sec == 6'd0);
        if (r_sec == 6'd59) begin
            w_up_sec = 6'd0;
            w_up_min = r_min + MIN_WIDTH'(1);
        end else begin
            w_up_sec = r_sec + 6'd1;
            w_up_min = r_min;
        end
        if (r_sec == 6'd0) begin
            w_dn_sec = 6'd59;
            w_dn_min = r_min - MIN_WIDTH'(1);
        end else begin
            w_dn_sec = r_sec - 6'd1;
            w_dn_min = r_min;
        end
        w_dn_zero = (w_dn_min == '0) && (w_dn_sec == 6'd0);
    end

    // FIFO push/pop decisions and the head that will be visible after this edge
    always_comb begin
        w_pop       = lap_rd && r_lap_valid;
        w_want_push = lap && (r_state == ST_RUN);
        w_push      = w_want_push && (!r_lap_full || w_pop);
        w_drop      = w_want_push && r_lap_full && !w_pop;
        w_rd_next   = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
        w_cnt_next  = r_count + CW'(w_push) - CW'(w_pop);
        if (w_cnt_next == '0) begin
            w_head_min = '0;
            w_head_sec = 6'd0;
        end else if (w_push && (r_wr_ptr == w_rd_next)) begin
            // The entry becoming head is the one being written this edge
            w_head_min = r_min;
            w_head_sec = r_sec;
        end else begin
            w_head_min = r_mem_min[w_rd_next];
            w_head_sec = r_mem_sec[w_rd_next];
        end
    end

    // Control FSM, prescaler and time count; reset > load > stop > start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_presc     <= '0;
            r_min       <= '0;
            r_sec       <= 6'd0;
            r_mode_down <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (reset) begin
                r_state <= ST_IDLE;
                r_presc <= '0;
                r_min   <= '0;
                r_sec   <= 6'd0;
            end else if (load && (r_state != ST_RUN)) begin
                r_state <= ST_IDLE;
                r_presc <= '0;
                r_min   <= load_min;
                r_sec   <= w_load_sec;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !(mode_down && w_zero)) begin
                            r_state     <= ST_RUN;
                            r_mode_down <= mode_down;
                            r_presc     <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            r_state <= ST_PAUSE;
                        end else if (r_presc == PRESC_LAST) begin
                            r_presc <= '0;
                            if (r_mode_down) begin
                                r_min <= w_dn_min;
                                r_sec <= w_dn_sec;
                                if (w_dn_zero) begin
                                    r_state   <= ST_EXP;
                                    r_expired <= 1'b1;
                                end
                            end else begin
                                r_min <= w_up_min;
                                r_sec <= w_up_sec;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_EXP: begin
                        r_state <= ST_EXP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Lap FIFO storage, pointers, flags and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_mem_min[i] <= '0;
                r_mem_sec[i] <= 6'd0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lap_valid <= 1'b0;
            r_lap_full  <= 1'b0;
            r_lap_ovf   <= 1'b0;
            r_head_min  <= '0;
            r_head_sec  <= 6'd0;
        end else if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lap_valid <= 1'b0;
            r_lap_full  <= 1'b0;
            r_lap_ovf   <= 1'b0;
            r_head_min  <= '0;
            r_head_sec  <= 6'd0;
        end else begin
            if (w_push) begin
                r_mem_min[r_wr_ptr] <= r_min;
                r_mem_sec[r_wr_ptr] <= r_sec;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_drop) begin
                r_lap_ovf <= 1'b1;
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_cnt_next;
            r_lap_valid <= (w_cnt_next != '0);
            r_lap_full  <= (w_cnt_next == FIFO_FULL);
            r_head_min  <= w_head_min;
            r_head_sec  <= w_head_sec;
        end
    end

    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign status    = r_state;
    assign expired   = r_expired;
    assign lap_valid = r_lap_valid;
    assign lap_min   = r_head_min;
    assign lap_sec   = r_head_sec;
    assign lap_full  = r_lap_full;
    assign lap_ovf   = r_lap_ovf;

endmodule

// File: tb/tb_stopwatch_multimode.sv
// Bench for stopwatch_multimode: total-seconds/queue reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_stopwatch_multimode;

    localparam int CPS   = 4;
    localparam int MW    = 2;
    localparam int DEPTH = 4;
    localparam int WRAP  = 60 * (1 << MW);

    logic          clk = 1'b0;
    logic          rst_n, start, stop, reset, mode_down, load, lap, lap_rd;
    logic [MW-1:0] load_min;
    logic [5:0]    load_sec;
    logic [MW-1:0] minutes, lap_min;
    logic [5:0]    seconds, lap_sec;
    logic [1:0]    status;
    logic          expired, lap_valid, lap_full, lap_ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: status as spec code, time as total seconds, queue of totals
    int m_state, m_total, m_sub;
    bit m_down, m_exp, m_ovf;
    int m_q[$];

    stopwatch_multimode #(.CLK_PER_SEC(CPS), .MIN_WIDTH(MW), .LAP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
        .lap(lap), .lap_rd(lap_rd), .minutes(minutes), .seconds(seconds),
        .status(status), .expired(expired), .lap_valid(lap_valid), .lap_min(lap_min),
        .lap_sec(lap_sec), .lap_full(lap_full), .lap_ovf(lap_ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = 0; m_total = 0; m_sub = 0;
        m_down = 1'b0; m_exp = 1'b0; m_ovf = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit pop, push;
        int ls;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_exp = 1'b0;
        if (reset) begin
            m_state = 0; m_total = 0; m_sub = 0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        pop  = lap_rd && (m_q.size() > 0);
        push = 1'b0;
        if (lap && m_state == 1) begin
            if (m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
            else push = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(m_total);
        if (load && m_state != 1) begin
            ls = (int'(load_sec) > 59) ? 59 : int'(load_sec);
            m_total = int'(load_min) * 60 + ls;
            m_sub = 0;
            m_state = 0;
        end else if (m_state == 1) begin
            if (stop) begin
                m_state = 2;
            end else begin
                m_sub++;
                if (m_sub == CPS) begin
                    m_sub = 0;
                    if (m_down) begin
                        m_total--;
                        if (m_total == 0) begin
                            m_state = 3;
                            m_exp = 1'b1;
                        end
                    end else begin
                        m_total = (m_total + 1) % WRAP;
                    end
                end
            end
        end else if (m_state == 0 && start && !(mode_down && m_total == 0)) begin
            m_state = 1; m_down = mode_down; m_sub = 0;
        end else if (m_state == 2 && start) begin
            m_state = 1;
        end
    endfunction

    function automatic void compare();
        int hm, hs;
        hm = (m_q.size() > 0) ? m_q[0] / 60 : 0;
        hs = (m_q.size() > 0) ? m_q[0] % 60 : 0;
        chk("minutes",   int'(minutes),   m_total / 60);
        chk("seconds",   int'(seconds),   m_total % 60);
        chk("status",    int'(status),    m_state);
        chk("expired",   int'(expired),   int'(m_exp));
        chk("lap_valid", int'(lap_valid), int'(m_q.size() > 0));
        chk("lap_min",   int'(lap_min),   hm);
        chk("lap_sec",   int'(lap_sec),   hs);
        chk("lap_full",  int'(lap_full),  int'(m_q.size() == DEPTH));
        chk("lap_ovf",   int'(lap_ovf),   int'(m_ovf));
    endfunction

    // Compare at the falling edge, then advance the model on the rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            model_step();
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1; cyc(1); reset = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0; mode_down = 1'b0;
        load = 1'b0; lap = 1'b0; lap_rd = 1'b0; load_min = '0; load_sec = 6'd0;
        model_reset();
        cyc(3);
        chk("lit_reset_status", int'(status), 0);
        rst_n = 1'b1;
        cyc(1);

        // Up count: 244 cycles after the start edge is 61 seconds
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(244);
        chk("lit_up_min", int'(minutes), 1);
        chk("lit_up_sec", int'(seconds), 1);
        chk("lit_up_status", int'(status), 1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        pulse_reset();

        // Pause/resume keeps the partial second
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(6);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("lit_pause_status", int'(status), 2);
        cyc(20);
        chk("lit_pause_hold", int'(seconds), 1);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        chk("lit_resume_1", int'(seconds), 1);
        cyc(1);
        chk("lit_resume_2", int'(seconds), 2);
        stop = 1'b1; cyc(1); stop = 1'b0;
        pulse_reset();

        // Countdown from 00:02
        load_min = 2'd0; load_sec = 6'd2; load = 1'b1; cyc(1); load = 1'b0;
        mode_down = 1'b1; start = 1'b1; cyc(1); start = 1'b0; mode_down = 1'b0;
        cyc(7);
        chk("lit_dn_pre_exp", int'(expired), 0);
        cyc(1);
        chk("lit_dn_expired", int'(expired), 1);
        chk("lit_dn_status", int'(status), 3);
        chk("lit_dn_sec", int'(seconds), 0);
        cyc(1);
        chk("lit_dn_pulse_end", int'(expired), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("lit_exp_start_ign", int'(status), 3);
        load_sec = 6'd5; load = 1'b1; cyc(1); load = 1'b0;
        chk("lit_reload_status", int'(status), 0);
        chk("lit_reload_sec", int'(seconds), 5);
        load_min = 2'd1; load_sec = 6'd63; load = 1'b1; cyc(1); load = 1'b0;
        chk("lit_clamp_sec", int'(seconds), 59);
        pulse_reset();
        mode_down = 1'b1; start = 1'b1; cyc(1); start = 1'b0; mode_down = 1'b0;
        chk("lit_dn_zero_start", int'(status), 0);

        // Lap FIFO: five laps, one dropped, then drain
        start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(4);
            lap = 1'b1; cyc(1); lap = 1'b0;
        end
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("lit_lap_full", int'(lap_full), 1);
        chk("lit_lap_ovf", int'(lap_ovf), 1);
        for (int k = 0; k < 4; k++) begin
            chk("lit_lap_valid", int'(lap_valid), 1);
            chk("lit_lap_sec", int'(lap_sec), k + 1);
            lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
        end
        lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
        chk("lit_lap_empty", int'(lap_valid), 0);
        pulse_reset();

        // Simultaneous push and pop on a full FIFO
        start = 1'b1; cyc(1); start = 1'b0;
        lap = 1'b1; cyc(4);
        lap_rd = 1'b1; cyc(1); lap = 1'b0; lap_rd = 1'b0;
        chk("lit_pp_full", int'(lap_full), 1);
        chk("lit_pp_no_ovf", int'(lap_ovf), 0);

        // Priority: reset beats load and start while running
        cyc(3);
        reset = 1'b1; load = 1'b1; start = 1'b1; load_min = 2'd1; load_sec = 6'd10;
        cyc(1);
        reset = 1'b0; load = 1'b0; start = 1'b0;
        chk("lit_prio_sec", int'(seconds), 0);
        chk("lit_prio_status", int'(status), 0);
        chk("lit_prio_fifo", int'(lap_valid), 0);

        // Wrap at maximum minutes, then async reset mid-second
        load_min = 2'd3; load_sec = 6'd59; load = 1'b1; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4);
        chk("lit_wrap_min", int'(minutes), 0);
        chk("lit_wrap_sec", int'(seconds), 0);
        chk("lit_wrap_status", int'(status), 1);
        cyc(3);
        rst_n = 1'b0; model_reset();
        #1;
        chk("lit_arst_status", int'(status), 0);
        chk("lit_arst_sec", int'(seconds), 0);
        cyc(2);
        rst_n = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        chk("lit_after_arst_0", int'(seconds), 0);
        cyc(1);
        chk("lit_after_arst_1", int'(seconds), 1);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
